// File: rtl/tl45_prefetch_if.sv
// Instruction memory request/acknowledge bus.
// Handshake: the master raises mem_req with mem_addr and holds both steady
// until the slave pulses mem_ack for one cycle together with mem_data. The
// transfer completes on the clock edge where mem_req and mem_ack are both
// high. The bus cannot abort, so a request always runs to its ack.
interface tl45_prefetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_data;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/tl45_prefetch.sv
// TL45 instruction fetch stage: issues word fetches on the memory bus, queues
// returned {pc, inst} pairs in a DEPTH-entry FIFO and presents one per cycle
// to decode. Redirects (flush / new PC) clear the FIFO. A redirect that lands
// while a request is outstanding parks the FSM in DISCARD until the stale ack
// arrives.
module tl45_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_pipe_stall,
   input  logic                  i_pipe_flush,
   input  logic                  i_new_pc,
   input  logic [31:0]           i_pc,
   tl45_prefetch_if.master       mem_bus,
   output logic [31:0]           o_buf_pc,
   output logic [31:0]           o_buf_inst,
   output logic                  o_buf_valid,
   output logic [1:0]            o_dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_ONE   = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_mem_req;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_deliver_pc;
   logic [31:0]   r_fifo_pc   [DEPTH];
   logic [31:0]   r_fifo_inst [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_redirect;
   logic [31:0]   w_redir_pc;
   logic          w_ack;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_count_next;
   logic          w_credit_now;
   logic          w_credit_next;
   logic [31:0]   w_fetch_inc;
   logic [31:0]   w_head_pc;
   logic [31:0]   w_head_inst;

   // Redirect target: masking keeps the word alignment explicit.
   assign w_redirect    = i_pipe_flush | i_new_pc;
   assign w_redir_pc    = i_new_pc ? (i_pc & ~32'h3) : r_deliver_pc;
   assign w_ack         = mem_bus.mem_ack;
   // Only an ack in REQ carries live data; acks in DISCARD or under redirect drop.
   assign w_push        = (r_state == S_REQ) && w_ack && !w_redirect;
   assign w_pop         = !w_redirect && !i_pipe_stall && (r_count != '0);
   assign w_count_next  = r_count + (w_push ? C_ONE : '0) - (w_pop ? C_ONE : '0);
   // A credit is one FIFO slot not already claimed by data or an outstanding request.
   assign w_credit_now  = (r_count < C_DEPTH);
   assign w_credit_next = (w_count_next < C_DEPTH);
   assign w_fetch_inc   = r_fetch_pc + 32'd4;
   assign w_head_pc     = r_fifo_pc[r_rd_ptr];
   assign w_head_inst   = r_fifo_inst[r_rd_ptr];

   assign mem_bus.mem_req  = r_mem_req;
   assign mem_bus.mem_addr = r_mem_addr;
   assign o_dbg_state      = r_state;

   // Fetch FSM: owns fetch_pc and the registered bus request/address.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_mem_req  <= 1'b0;
         r_mem_addr <= 32'h0;
      end else if (w_redirect) begin
         r_fetch_pc <= w_redir_pc;
         if ((r_state != S_IDLE) && !w_ack) begin
            // Request still in flight at the old address: wait it out.
            r_state <= S_DISCARD;
         end else begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_credit_now) begin
                  r_state    <= S_REQ;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= r_fetch_pc;
               end
            end
            S_REQ: begin
               if (w_ack) begin
                  r_fetch_pc <= w_fetch_inc;
                  if (w_credit_next) begin
                     r_mem_addr <= w_fetch_inc;
                  end else begin
                     r_state   <= S_IDLE;
                     r_mem_req <= 1'b0;
                  end
               end
            end
            S_DISCARD: begin
               if (w_ack) begin
                  if (w_credit_next) begin
                     r_state    <= S_REQ;
                     r_mem_addr <= r_fetch_pc;
                  end else begin
                     r_state   <= S_IDLE;
                     r_mem_req <= 1'b0;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Prefetch FIFO and decode-facing output buffer.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count      <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         o_buf_pc     <= 32'h0;
         o_buf_inst   <= 32'h0;
         o_buf_valid  <= 1'b0;
         r_deliver_pc <= RESET_PC;
      end else if (w_redirect) begin
         r_count      <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         o_buf_pc     <= 32'h0;
         o_buf_inst   <= 32'h0;
         o_buf_valid  <= 1'b0;
         r_deliver_pc <= w_redir_pc;
      end else begin
         if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
            r_fifo_inst[r_wr_ptr] <= mem_bus.mem_data;
            r_wr_ptr              <= r_wr_ptr + PTR_ONE;
         end
         if (!i_pipe_stall) begin
            if (r_count != '0) begin
               o_buf_pc     <= w_head_pc;
               o_buf_inst   <= w_head_inst;
               o_buf_valid  <= 1'b1;
               r_deliver_pc <= w_head_pc + 32'd4;
               r_rd_ptr     <= r_rd_ptr + PTR_ONE;
            end else begin
               o_buf_pc    <= 32'h0;
               o_buf_inst  <= 32'h0;
               o_buf_valid <= 1'b0;
            end
         end
         r_count <= w_count_next;
      end
   end

endmodule

// File: tb/tb_tl45_prefetch.sv
// Bench for tl45_prefetch: a latency-programmable memory model, a scoreboard
// of expected PCs per scenario, and directed timing checks.
module tb_tl45_prefetch;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_pipe_stall;
   logic        i_pipe_flush;
   logic        i_new_pc;
   logic [31:0] i_pc;
   logic [31:0] o_buf_pc;
   logic [31:0] o_buf_inst;
   logic        o_buf_valid;
   logic [1:0]  o_dbg_state;

   tl45_prefetch_if mem ();

   tl45_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_pipe_stall (i_pipe_stall),
      .i_pipe_flush (i_pipe_flush),
      .i_new_pc     (i_new_pc),
      .i_pc         (i_pc),
      .mem_bus      (mem),
      .o_buf_pc     (o_buf_pc),
      .o_buf_inst   (o_buf_inst),
      .o_buf_valid  (o_buf_valid),
      .o_dbg_state  (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];
   logic        mon_en   = 1'b0;
   int          mem_lat  = 0;
   int          n_acks   = 0;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   // Instruction word differs from its address so swapped fields are visible.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- memory model (drives 2 units after the edge) ----------------
   initial begin
      int          wcnt;
      logic        prev_req;
      logic        prev_ack;
      logic [31:0] prev_addr;
      wcnt = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
      mem.mem_ack  = 1'b0;
      mem.mem_data = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (!i_reset && prev_req && !prev_ack && mem.mem_req)
            check("addr_stable", mem.mem_addr, prev_addr);
         if (i_reset || !mem.mem_req) begin
            mem.mem_ack = 1'b0;
            wcnt = 0;
         end else begin
            if (mem.mem_ack) wcnt = 0;
            if (wcnt >= mem_lat) begin
               mem.mem_ack  = 1'b1;
               mem.mem_data = mem_word(mem.mem_addr);
               n_acks++;
            end else begin
               mem.mem_ack = 1'b0;
               wcnt++;
            end
         end
         prev_req  = mem.mem_req && !i_reset;
         prev_ack  = mem.mem_ack;
         prev_addr = mem.mem_addr;
      end
   end

   // ---------------- scoreboard monitor (1 unit after the edge) ----------------
   initial begin
      logic        stall_seen;
      logic [31:0] e;
      forever begin
         @(posedge clk);
         stall_seen = i_pipe_stall;
         #1;
         if (!o_buf_valid) begin
            check("bubble_pc", o_buf_pc, 32'h0);
            check("bubble_inst", o_buf_inst, 32'h0);
         end else if (mon_en && !stall_seen) begin
            check("sb_has_exp", {31'h0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_pc", o_buf_pc, e);
               check("sb_inst", o_buf_inst, mem_word(e));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge clk);
      mon_en = 1'b0;
      i_reset = 1'b1;
      i_pipe_stall = 1'b0;
      i_pipe_flush = 1'b0;
      i_new_pc = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, exp_q.size(), 32'h0);
      exp_q.delete();
   endtask

   task automatic wait_req(input string tag, input int budget);
      int n;
      n = 0;
      while (!mem.mem_req && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'h0, mem.mem_req}, 32'h1);
   endtask

   task automatic wait_ack(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem.mem_ack && n < budget);
      check(tag, {31'h0, mem.mem_ack}, 32'h1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},   {31'h0, mem.mem_req}, 32'h0);
      check({tag, "_addr"},  mem.mem_addr, 32'h0);
      check({tag, "_pc"},    o_buf_pc, 32'h0);
      check({tag, "_inst"},  o_buf_inst, 32'h0);
      check({tag, "_valid"}, {31'h0, o_buf_valid}, 32'h0);
      check({tag, "_state"}, {30'h0, o_dbg_state}, {30'h0, ST_IDLE});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      i_reset = 1'b1; i_pipe_stall = 1'b0; i_pipe_flush = 1'b0;
      i_new_pc = 1'b0; i_pc = 32'h0;
      repeat (3) @(negedge clk);
      check_all_zero("rst");

      // T1: continuous ack from reset, 1 instruction per cycle.
      for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
      mon_en = 1'b1;
      i_reset = 1'b0;
      @(negedge clk) check("t1_lat1", {31'h0, o_buf_valid}, 32'h0);
      @(negedge clk) check("t1_lat2", {31'h0, o_buf_valid}, 32'h0);
      @(negedge clk) check("t1_lat3", {31'h0, o_buf_valid}, 32'h1);
      check("t1_first_pc", o_buf_pc, 32'h0);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         check("t1_thru", {31'h0, o_buf_valid}, 32'h1);
      end
      mon_en = 1'b0;
      wait_drain("t1_drain", 1);

      // T2: stall fills the FIFO to DEPTH, then release.
      apply_reset();
      i_pipe_stall = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
      mon_en = 1'b1;
      n_acks = 0;
      i_reset = 1'b0;
      repeat (10) @(negedge clk);
      check("t2_pushes", n_acks, 32'd4);
      check("t2_req_idle", {31'h0, mem.mem_req}, 32'h0);
      check("t2_valid_held", {31'h0, o_buf_valid}, 32'h0);
      i_pipe_stall = 1'b0;
      @(negedge clk);
      check("t2_out0", {31'h0, o_buf_valid}, 32'h1);
      check("t2_req_hold", {31'h0, mem.mem_req}, 32'h0);
      @(negedge clk);
      check("t2_out1", {31'h0, o_buf_valid}, 32'h1);
      check("t2_req_rise", {31'h0, mem.mem_req}, 32'h1);
      @(negedge clk) check("t2_out2", {31'h0, o_buf_valid}, 32'h1);
      @(negedge clk) check("t2_out3", {31'h0, o_buf_valid}, 32'h1);
      mon_en = 1'b0;
      wait_drain("t2_drain", 1);

      // T3: redirect during a slow request; the late data must be dropped.
      apply_reset();
      mem_lat = 3;
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      mon_en = 1'b1;
      i_reset = 1'b0;
      wait_req("t3_req", 10);
      i_new_pc = 1'b1;
      i_pc = 32'h100;
      @(negedge clk);
      i_new_pc = 1'b0;
      check("t3_discard", {30'h0, o_dbg_state}, {30'h0, ST_DISCARD});
      check("t3_old_addr", mem.mem_addr, 32'h0);
      wait_ack("t3_late_ack", 10);
      @(negedge clk);
      check("t3_next_req", {31'h0, mem.mem_req}, 32'h1);
      check("t3_next_addr", mem.mem_addr, 32'h100);
      wait_drain("t3_drain", 100);
      mon_en = 1'b0;

      // T4: flush without new PC refetches from the first undelivered PC.
      apply_reset();
      mem_lat = 0;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      mon_en = 1'b1;
      i_reset = 1'b0;
      wait_drain("t4_first", 20);
      i_pipe_flush = 1'b1;
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      exp_q.push_back(32'h10);
      @(negedge clk);
      i_pipe_flush = 1'b0;
      check("t4_bubble", {31'h0, o_buf_valid}, 32'h0);
      @(negedge clk);
      check("t4_req", {31'h0, mem.mem_req}, 32'h1);
      check("t4_refetch", mem.mem_addr, 32'h8);
      wait_drain("t4_resume", 30);
      mon_en = 1'b0;

      // T5: reset in the middle of an outstanding request.
      apply_reset();
      mem_lat = 3;
      exp_q.push_back(32'h0);
      mon_en = 1'b1;
      i_reset = 1'b0;
      wait_drain("t5_first", 30);
      mon_en = 1'b0;
      wait_req("t5_req_busy", 10);
      i_reset = 1'b1;
      @(negedge clk);
      check_all_zero("t5_rst");
      mem_lat = 0;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      mon_en = 1'b1;
      i_reset = 1'b0;
      @(negedge clk);
      check("t5_restart_req", {31'h0, mem.mem_req}, 32'h1);
      check("t5_restart_addr", mem.mem_addr, 32'h0);
      wait_drain("t5_drain", 30);
      mon_en = 1'b0;

      // T6: redirect near the top of memory; PC wraps, low bits ignored.
      apply_reset();
      mem_lat = 0;
      i_reset = 1'b0;
      repeat (6) @(negedge clk);
      i_new_pc = 1'b1;
      i_pc = 32'hFFFF_FFFB;
      exp_q.push_back(32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      mon_en = 1'b1;
      @(negedge clk);
      i_new_pc = 1'b0;
      check("t6_lat0", {31'h0, o_buf_valid}, 32'h0);
      @(negedge clk) check("t6_lat1", {31'h0, o_buf_valid}, 32'h0);
      @(negedge clk) check("t6_lat2", {31'h0, o_buf_valid}, 32'h0);
      @(negedge clk) check("t6_lat3", {31'h0, o_buf_valid}, 32'h1);
      check("t6_pc0", o_buf_pc, 32'hFFFF_FFF8);
      wait_drain("t6_drain", 20);
      mon_en = 1'b0;

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
